// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Writer side of the instruction memory. Takes a program as a byte stream
//   (valid/ready) and packs it MSB-first into WIDTH-bit words. Each word is
//   written to imem at sequential addresses starting from 0. The core is held
//   in reset (cpu_hold_o) until a complete program has been loaded.
//
//   Parameters
//     WIDTH   instruction word width (multiple of 8)
//     ADDR_W  imem address width
//     DEPTH   imem depth in words (<= 2**ADDR_W)
//
//   Ports
//     clk_i          system clock, rising edge
//     rst_i          asynchronous, active-high reset
//     start_i        1-cycle pulse, begins a new load (ignored in LOAD/WRITE)
//     in_valid_i     byte stream valid
//     in_ready_o     byte stream ready; a byte moves when valid && ready
//     in_data_i      byte; the first byte of a word lands in word[WIDTH-1 -: 8]
//     in_last_i      marks the final byte of the program
//     wr_en_o        imem write strobe, one cycle per word
//     wr_addr_o      imem write address
//     wr_data_o      imem write data
//     cpu_hold_o     1 = core held in reset
//     done_o         program loaded successfully
//     err_o          load aborted (truncated word or overflow)
//     word_count_o   words written in the current/last load
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [7:0]        in_data_i,
  input  logic              in_last_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [WIDTH-1:0]  wr_data_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_count_o
);

  localparam int BPW = WIDTH / 8;             // bytes per word
  localparam int BCW = $clog2(BPW + 1);       // byte counter width

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [BCW-1:0]    bcnt_q,  bcnt_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [ADDR_W:0]   wcnt_q,  wcnt_d;
  logic              last_q,  last_d;

  logic accept;
  logic word_full;
  logic at_top;

  assign accept    = (state_q == S_LOAD) && in_valid_i;
  // The byte being accepted now completes the word.
  assign word_full = (bcnt_q == BCW'(BPW - 1));
  assign at_top    = (addr_q == ADDR_W'(DEPTH - 1));

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      shreg_q <= '0;
      addr_q  <= '0;
      wcnt_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      last_q  <= last_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    last_d  = last_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        // A new load restarts from address 0 with empty counters. Memory
        // written by an earlier load is simply overwritten.
        if (start_i) begin
          state_d = S_LOAD;
          bcnt_d  = '0;
          addr_d  = '0;
          wcnt_d  = '0;
          last_d  = 1'b0;
        end
      end

      S_LOAD: begin
        if (accept) begin
          // Shift rather than index so the first byte ends up in the MSBs.
          shreg_d = (shreg_q << 8) | WIDTH'(in_data_i);
          bcnt_d  = bcnt_q + BCW'(1);
          if (word_full) begin
            state_d = S_WRITE;
            last_d  = in_last_i;
          end else if (in_last_i) begin
            // Program ended inside a word: nothing to write.
            state_d = S_ERR;
          end
        end
      end

      S_WRITE: begin
        addr_d = addr_q + ADDR_W'(1);
        wcnt_d = wcnt_q + (ADDR_W + 1)'(1);
        bcnt_d = '0;
        if (last_q)      state_d = S_DONE;
        else if (at_top) state_d = S_ERR;   // no room for another word
        else             state_d = S_LOAD;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from state or taken straight from registers, so they
  // follow the async reset immediately and never depend on live inputs.
  // ---------------------------------------------------------------------------
  assign in_ready_o   = (state_q == S_LOAD);
  assign wr_en_o      = (state_q == S_WRITE);
  assign wr_addr_o    = addr_q;
  assign wr_data_o    = shreg_q;
  assign cpu_hold_o   = (state_q != S_DONE);
  assign done_o       = (state_q == S_DONE);
  assign err_o        = (state_q == S_ERR);
  assign word_count_o = wcnt_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 0;
  logic              rst = 1;
  logic              start = 0;
  logic              in_valid = 0;
  logic              in_ready;
  logic [7:0]        in_data = '0;
  logic              in_last = 0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              cpu_hold, done, err;
  logic [ADDR_W:0]   word_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [35:0] wq[$];   // observed writes {addr, data}

  imem_loader #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .in_last_i(in_last), .wr_en_o(wr_en), .wr_addr_o(wr_addr),
    .wr_data_o(wr_data), .cpu_hold_o(cpu_hold), .done_o(done),
    .err_o(err), .word_count_o(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // Write monitor: records every write and checks the stream is stalled then.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      wq.push_back({wr_addr, wr_data});
      chk("ready_low_in_write", in_ready, 0);
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_cpu_hold"}, cpu_hold, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_wcnt"}, word_count, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask

  // Present one byte until it is taken (bounded), then drop valid.
  task automatic put_byte(input logic [7:0] d, input bit l);
    int cyc = 0;
    bit fire = 0;
    while (!fire && cyc < 20) begin
      @(negedge clk); cyc++;
      in_valid = 1; in_data = d; in_last = l;
      fire = in_ready;
      @(posedge clk);
    end
    #1 in_valid = 0; in_last = 0;
    chk("put_byte_taken", fire, 1);
  endtask

  task automatic wait_end();
    int cyc = 0;
    while (!done && !err && cyc < 20) begin @(negedge clk); cyc++; end
    chk("load_terminates", done | err, 1);
  endtask

  // Stream a program (optionally with valid gaps); stop when the loader ends.
  task automatic feed(input logic [7:0] b[$], input bit hl, input bit gaps, output int acc);
    int i = 0, cyc = 0;
    bit fire;
    acc = 0;
    while (i < b.size() && cyc < 3000) begin
      @(negedge clk); cyc++;
      if (done || err) break;
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = b[i];
      in_last  = hl && (i == b.size() - 1);
      fire     = in_valid && in_ready;
      @(posedge clk);
      if (fire) begin i++; acc++; end
    end
    @(negedge clk); in_valid = 0; in_last = 0;
    wait_end();
  endtask

  // Reference: words are groups of 4 bytes; the load ends at the last byte,
  // errors if it ends mid-word, and errors after DEPTH words without last.
  task automatic model(input logic [7:0] b[$], input bit hl, output int acc,
                       output bit dn, output bit er, output logic [35:0] ew[$]);
    int n = b.size();
    acc = 0; dn = 0; er = 0; ew.delete();
    for (int w = 0; w < DEPTH; w++) begin
      int base = 4 * w;
      if (hl && n - base < 4) begin acc = n; er = 1; return; end
      ew.push_back({ADDR_W'(w), b[base], b[base+1], b[base+2], b[base+3]});
      acc = base + 4;
      if (hl && n == base + 4) begin dn = 1; return; end
    end
    er = 1;
  endtask

  typedef struct {
    logic [63:0] bv;   // bytes, first byte in the MSBs
    int          nb;
    bit          gaps;
    int          wc;
    bit          dn;
    bit          er;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  initial begin
    vec_t        tbl[6];
    logic [7:0]  b[$];
    logic [35:0] ew[$];
    int          acc, eacc;
    bit          edn, eer;
    bit          hl;
    int          n;

    tbl[0] = '{64'h123456789ABCDEF0, 8, 0, 2, 1, 0, 32'h12345678, 32'h9ABCDEF0};
    tbl[1] = '{64'h123456789ABCDEF0, 8, 1, 2, 1, 0, 32'h12345678, 32'h9ABCDEF0};
    tbl[2] = '{64'hAABBCC0000000000, 3, 0, 0, 0, 1, 32'h0, 32'h0};
    tbl[3] = '{64'hDEADBEEF00000000, 4, 1, 1, 1, 0, 32'hDEADBEEF, 32'h0};
    tbl[4] = '{64'h0102030405000000, 5, 0, 1, 0, 1, 32'h01020304, 32'h0};
    tbl[5] = '{64'hCAFEF00D11223344, 8, 1, 2, 1, 0, 32'hCAFEF00D, 32'h11223344};

    // Reset state, then reset values after release.
    #12;
    check_reset_vals("por");
    @(negedge clk); rst = 0;
    @(negedge clk);
    check_reset_vals("idle");

    // Table-driven programs.
    foreach (tbl[t]) begin
      b.delete();
      for (int i = 0; i < tbl[t].nb; i++) b.push_back(tbl[t].bv[63 - 8*i -: 8]);
      wq.delete();
      pulse_start();
      feed(b, 1'b1, tbl[t].gaps, acc);
      chk($sformatf("v%0d_accepted", t), acc, tbl[t].nb);
      chk($sformatf("v%0d_nwrites", t), wq.size(), tbl[t].wc);
      chk($sformatf("v%0d_wcnt", t), word_count, tbl[t].wc);
      chk($sformatf("v%0d_done", t), done, tbl[t].dn);
      chk($sformatf("v%0d_err", t), err, tbl[t].er);
      chk($sformatf("v%0d_hold", t), cpu_hold, !tbl[t].dn);
      chk($sformatf("v%0d_ready", t), in_ready, 0);
      if (tbl[t].wc > 0 && wq.size() > 0) chk($sformatf("v%0d_w0", t), wq[0], {4'd0, tbl[t].w0});
      if (tbl[t].wc > 1 && wq.size() > 1) chk($sformatf("v%0d_w1", t), wq[1], {4'd1, tbl[t].w1});
    end

    // Overflow: 17 words without last.
    b.delete();
    for (int i = 0; i < 4 * (DEPTH + 1); i++) b.push_back(8'(i * 7 + 3));
    wq.delete();
    pulse_start();
    feed(b, 1'b0, 1'b0, acc);
    chk("ovf_accepted", acc, 4 * DEPTH);
    chk("ovf_nwrites", wq.size(), DEPTH);
    chk("ovf_wcnt", word_count, DEPTH);
    chk("ovf_err", err, 1);
    chk("ovf_ready", in_ready, 0);
    chk("ovf_hold", cpu_hold, 1);
    if (wq.size() == DEPTH)
      chk("ovf_last_write", wq[DEPTH-1], {4'(DEPTH-1), b[60], b[61], b[62], b[63]});

    // start during LOAD is ignored: the partial word survives it.
    wq.delete();
    pulse_start();
    put_byte(8'hAA, 0); put_byte(8'hBB, 0);
    pulse_start();
    put_byte(8'hCC, 0); put_byte(8'hDD, 1);
    wait_end();
    chk("ign_nwrites", wq.size(), 1);
    if (wq.size() > 0) chk("ign_w0", wq[0], {4'd0, 32'hAABBCCDD});
    chk("ign_done", done, 1);
    chk("ign_hold", cpu_hold, 0);

    // start from DONE: hold reasserts as soon as the state leaves DONE.
    @(negedge clk); start = 1;
    @(posedge clk); #1;
    chk("redo_hold", cpu_hold, 1);
    chk("redo_ready", in_ready, 1);
    chk("redo_done", done, 0);
    chk("redo_wcnt", word_count, 0);
    @(negedge clk); start = 0;

    // Reset asserted mid-cycle during LOAD after 2 bytes.
    put_byte(8'h55, 0); put_byte(8'h66, 0);
    @(posedge clk); #3 rst = 1;
    #1 check_reset_vals("midrst");
    @(negedge clk); rst = 0;
    wq.delete();
    pulse_start();
    put_byte(8'h01, 0); put_byte(8'h23, 0); put_byte(8'h45, 0); put_byte(8'h67, 1);
    wait_end();
    chk("rst_nwrites", wq.size(), 1);
    if (wq.size() > 0) chk("rst_w0", wq[0], {4'd0, 32'h01234567});
    chk("rst_done", done, 1);
    chk("rst_wcnt", word_count, 1);

    // Randomized programs against the reference model.
    for (int r = 0; r < 20; r++) begin
      hl = ($urandom_range(0, 4) != 0);
      n  = hl ? int'($urandom_range(1, 72)) : 4 * DEPTH + int'($urandom_range(1, 8));
      b.delete();
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      model(b, hl, eacc, edn, eer, ew);
      wq.delete();
      pulse_start();
      feed(b, hl, $urandom_range(0, 1), acc);
      chk($sformatf("r%0d_accepted", r), acc, eacc);
      chk($sformatf("r%0d_nwrites", r), wq.size(), ew.size());
      chk($sformatf("r%0d_wcnt", r), word_count, ew.size());
      chk($sformatf("r%0d_done", r), done, edn);
      chk($sformatf("r%0d_err", r), err, eer);
      chk($sformatf("r%0d_hold", r), cpu_hold, !edn);
      for (int k = 0; k < ew.size() && k < wq.size(); k++)
        chk($sformatf("r%0d_write%0d", r, k), wq[k], ew[k]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
